// File: rtl/relu_serializer_pkg.sv
// Shared defaults and FSM state encoding for the ReLU triplet serializer.
package relu_serializer_pkg;

  localparam int CONV_BIT_DEF = 12;
  localparam int OUT_BIT_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2,
    CH2  = 2'd3
  } state_t;

endpackage

// File: rtl/relu_quant.sv
// One-channel ReLU, divide-by-4 and unsigned saturation (purely combinational).
// Define RELU_ROUND_EN to round half up before saturating instead of truncating.
module relu_quant
  import relu_serializer_pkg::*;
#(
  parameter int CONV_BIT = CONV_BIT_DEF,
  parameter int OUT_BIT  = OUT_BIT_DEF
) (
  input  logic [CONV_BIT+1:0] x,
  output logic [OUT_BIT-1:0]  q
);

  // One spare bit so the rounding increment can never wrap.
  localparam int W = CONV_BIT + 3;

  logic [W-1:0] r;
  logic [W-1:0] s;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    r = '0;
    if (!x[CONV_BIT+1]) r = {1'b0, x};
`ifdef RELU_ROUND_EN
    s = (r + W'(2)) >> 2;
`else
    s = r >> 2;
`endif
    q = (s > W'((1 << OUT_BIT) - 1)) ? '1 : s[OUT_BIT-1:0];
  end

endmodule

// File: rtl/relu_serializer.sv
// Quantizes pooled triplets, queues them in a small FIFO and serializes one
// channel per handshake. Rounding mode follows the RELU_ROUND_EN macro (see relu_quant).
module relu_serializer
  import relu_serializer_pkg::*;
#(
  parameter int CONV_BIT   = CONV_BIT_DEF,
  parameter int OUT_BIT    = OUT_BIT_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [CONV_BIT+1:0] avg_value_1,
  input  logic [CONV_BIT+1:0] avg_value_2,
  input  logic [CONV_BIT+1:0] avg_value_3,
  output logic [OUT_BIT-1:0]  data_out,
  output logic [1:0]          ch_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                overflow
);

  localparam int CW = FIFO_AW + 1;

  logic [2:0][OUT_BIT-1:0] wr_data;
  logic [2:0][OUT_BIT-1:0] head;
  logic [2:0][OUT_BIT-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]           count, count_nxt;
  logic                    full, push, pop;
  state_t                  state, state_nxt;

  relu_quant #(.CONV_BIT(CONV_BIT), .OUT_BIT(OUT_BIT)) u_quant0 (.x(avg_value_1), .q(wr_data[0]));
  relu_quant #(.CONV_BIT(CONV_BIT), .OUT_BIT(OUT_BIT)) u_quant1 (.x(avg_value_2), .q(wr_data[1]));
  relu_quant #(.CONV_BIT(CONV_BIT), .OUT_BIT(OUT_BIT)) u_quant2 (.x(avg_value_3), .q(wr_data[2]));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = (state == CH2) && ready_in;
  assign push      = valid_in && (!full || pop);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head      = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    valid_out = 1'b0;
    ch_out    = 2'd0;
    data_out  = '0;
    case (state)
      IDLE: if (count != '0) state_nxt = CH0;
      CH0: begin
        valid_out = 1'b1;
        data_out  = head[0];
        if (ready_in) state_nxt = CH1;
      end
      CH1: begin
        valid_out = 1'b1;
        ch_out    = 2'd1;
        data_out  = head[1];
        if (ready_in) state_nxt = CH2;
      end
      CH2: begin
        valid_out = 1'b1;
        ch_out    = 2'd2;
        data_out  = head[2];
        // Restart directly at CH0 when anything remains, so entries stream without a bubble.
        if (ready_in) state_nxt = (count_nxt != '0) ? CH0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (valid_in && !push) overflow <= 1'b1;
    end
  end

  // NOTE: storage is left unreset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_relu_serializer.sv
// Scoreboard bench for relu_serializer: expected channel values are queued at
// drive time and compared whenever the DUT completes an output handshake.
module tb_relu_serializer;

  localparam int IN_W = 14;

`ifdef RELU_ROUND_EN
  localparam int Q_OF_6 = 2;
`else
  localparam int Q_OF_6 = 1;
`endif

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            valid_in;
  logic [IN_W-1:0] avg_value_1, avg_value_2, avg_value_3;
  logic [7:0]      data_out;
  logic [1:0]      ch_out;
  logic            valid_out;
  logic            ready_in;
  logic            overflow;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;

  relu_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .avg_value_1(avg_value_1),
    .avg_value_2(avg_value_2),
    .avg_value_3(avg_value_3),
    .data_out   (data_out),
    .ch_out     (ch_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model_q(input int x);
    int r;
    r = (x < 0) ? 0 : x;
`ifdef RELU_ROUND_EN
    r = (r + 2) / 4;
`else
    r = r / 4;
`endif
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input int a, input int b, input int c,
                          input int e0, input int e1, input int e2, input bit accept);
    valid_in    = 1'b1;
    avg_value_1 = IN_W'(a);
    avg_value_2 = IN_W'(b);
    avg_value_3 = IN_W'(c);
    if (accept) begin
      sb.push_back(exp_t'{ch: 2'd0, data: 8'(e0)});
      sb.push_back(exp_t'{ch: 2'd1, data: 8'(e1)});
      sb.push_back(exp_t'{ch: 2'd2, data: 8'(e2)});
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int c, input bit accept);
    send_exp(a, b, c, model_q(a), model_q(b), model_q(c), accept);
  endtask

  task automatic wait_outs(input int target, input string tag);
    for (int i = 0; i < 400 && n_out < target; i++) tick();
    check(tag, n_out, target);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Output monitor: consumes one expectation per completed handshake.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(valid_out), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", 32'(data_out), 32'(mon_e.data));
        check("ch_out", 32'(ch_out), 32'(mon_e.ch));
      end
      n_out++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    avg_value_1 = '0;
    avg_value_2 = '0;
    avg_value_3 = '0;
    do_reset();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Latency and basic values: 40, -12, 2000 -> 10, 0, 255.
    ready_in = 1'b1;
    base = n_out;
    send_exp(40, -12, 2000, 10, 0, 255, 1'b1);
    check("lat_edge_k", 32'(valid_out), 32'd0);
    tick();
    check("lat_edge_k1", 32'(valid_out), 32'd1);
    check("lat_ch0", 32'(ch_out), 32'd0);
    tick();
    check("seq_ch1", 32'(ch_out), 32'd1);
    tick();
    check("seq_ch2", 32'(ch_out), 32'd2);
    tick();
    check("idle_after", 32'(valid_out), 32'd0);
    check("idle_data", 32'(data_out), 32'd0);
    wait_outs(base + 3, "drain_basic");

    // Rounding boundary: 6 -> 1 or 2, 5 -> 1.
    base = n_out;
    send_exp(6, 5, 0, Q_OF_6, 1, 0, 1'b1);
    wait_outs(base + 3, "drain_round");

    // Spaced random triplets including range extremes.
    base = n_out;
    send(-8192, 8191, 1022, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
           int'($urandom_range(0, 1100)), 1'b1);
      tick();
      tick();
    end
    wait_outs(base + 21, "drain_random");

    // Back-to-back entries stream without a bubble.
    base = n_out;
    send(100, 4, 8, 1'b1);
    send(12, 16, 20, 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid_out) cnt++;
      tick();
    end
    check("no_bubble", cnt, 6);
    wait_outs(base + 6, "drain_b2b");

    // Stall mid-CH1 for five cycles.
    base = n_out;
    send_exp(100, 200, 300, 25, 50, 75, 1'b1);
    for (int i = 0; i < 20 && !(valid_out && ch_out == 2'd1); i++) tick();
    ready_in = 1'b0;
    check("stall_reach_ch1", 32'(ch_out), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold_data", 32'(data_out), 32'd50);
      check("stall_hold_ch", 32'(ch_out), 32'd1);
      check("stall_hold_valid", 32'(valid_out), 32'd1);
    end
    ready_in = 1'b1;
    tick();
    check("stall_resume_ch2", 32'(ch_out), 32'd2);
    wait_outs(base + 3, "drain_stall");

    // Overflow: five triplets into a stalled four-entry FIFO.
    do_reset();
    base = n_out;
    for (int i = 0; i < 5; i++) send(40 * (i + 1), 8 * i + 3, -i, i < 4);
    check("overflow_set", 32'(overflow), 32'd1);
    ready_in = 1'b1;
    wait_outs(base + 12, "drain_overflow");
    tick();
    tick();
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("overflow_idle", 32'(valid_out), 32'd0);

    // Full FIFO with push coincident with the CH2 pop.
    do_reset();
    base = n_out;
    for (int i = 0; i < 4; i++) send(4 * i + 4, 400 + i, 1000 + 4 * i, 1'b1);
    ready_in = 1'b1;
    tick();
    tick();
    check("full_at_ch2", 32'(ch_out), 32'd2);
    send(77, 88, 99, 1'b1);
    check("full_pop_push_ovf", 32'(overflow), 32'd0);
    wait_outs(base + 15, "drain_full");

    // Reset in CH1 with three entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) send(60 + i, 70 + i, 80 + i, 1'b1);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check("pre_rst_ch1", 32'(ch_out), 32'd1);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check("post_rst_valid", 32'(valid_out), 32'd0);
    check("post_rst_ovf", 32'(overflow), 32'd0);
    check("post_rst_ch", 32'(ch_out), 32'd0);
    ready_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid_out) cnt++;
      tick();
    end
    check("no_stale_outputs", cnt, 0);
    base = n_out;
    send(-1, 3000, 9, 1'b1);
    wait_outs(base + 3, "drain_after_rst");

    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/relu_serializer.md
RELU_SERIALIZER -- requirements
Module: relu_serializer

Interface
REQ-001 The block SHALL have parameter CONV_BIT, default 12: conv sample width; input width is CONV_BIT+2.
REQ-002 The block SHALL have parameter OUT_BIT, default 8: unsigned output sample width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: triplet FIFO entries, power of two.
REQ-004 The block SHALL have parameter FIFO_AW, default 2: log2(FIFO_DEPTH).
REQ-005 The block SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 The block SHALL have port valid_in, input, 1: pooled triplet present this cycle.
REQ-008 The block SHALL have ports avg_value_1/2/3, input, CONV_BIT+2 each: pooled 4-sample sums, treated as signed.
REQ-009 The block SHALL have port data_out, output, OUT_BIT: serialized activation.
REQ-010 The block SHALL have port ch_out, output, 2: channel index of data_out (0,1,2).
REQ-011 The block SHALL have port valid_out, output, 1: data_out/ch_out valid.
REQ-012 The block SHALL have port ready_in, input, 1: downstream accepts when valid_out && ready_in.
REQ-013 The block SHALL have port overflow, output, 1: sticky flag, triplet dropped.

Function
REQ-014 Per channel SHALL compute: r = (x<0) ? 0 : x; q = r>>2 (divide by 4, pool average); q saturated to 2^OUT_BIT-1.
REQ-015 Push: valid_in high and (FIFO not full or pop in same cycle) SHALL write the three q values as one entry.
REQ-016 valid_in high, FIFO full, no pop same cycle: triplet SHALL be dropped, overflow set to 1, FIFO unchanged.
REQ-017 FSM states IDLE, CH0, CH1, CH2; IDLE->CH0 when FIFO non-empty; CHn->CHn+1 on handshake; CH2->CH0 on handshake if FIFO holds another entry after pop, else CH2->IDLE.
REQ-018 valid_out SHALL be 1 exactly in CH0..CH2; ch_out SHALL equal the state index; data_out the head-entry channel value.
REQ-019 Outputs SHALL hold stable while valid_out && !ready_in.
REQ-020 Head entry SHALL pop on CH2 handshake; back-to-back entries SHALL stream without bubble.
REQ-021 Latency: triplet accepted at edge k into empty FIFO, IDLE FSM -> valid_out, ch_out=0 after edge k+1.
REQ-022 In IDLE, data_out SHALL be 0 and ch_out 0.
REQ-023 Pointer wrap SHALL be modulo FIFO_DEPTH; full/empty distinguished by a FIFO_AW+1-bit count.

Reset
REQ-024 rst high at an edge SHALL set FSM IDLE, FIFO count and pointers 0, valid_out 0, data_out 0, ch_out 0, overflow 0.
REQ-025 rst mid-frame SHALL discard all stored entries and any partially serialized triplet; the first valid_in after rst deasserts is accepted normally.
REQ-026 overflow SHALL clear only on rst.

Configuration
REQ-027 Macro RELU_ROUND_EN defined: q = (r+2)>>2 (round half up) before saturation; undefined: q = r>>2 (truncate); nothing else changes.

Structure
REQ-028 Shared package SHALL hold CONV_BIT/OUT_BIT defaults and the FSM state encoding constants (IDLE=0, CH0=1, CH1=2, CH2=3).
REQ-029 One sub-module relu_quant (combinational ReLU/shift/saturate, one channel) SHALL be instantiated three times; FIFO and FSM stay in relu_serializer.

Verification
REQ-030 Inputs (40,-12,8191 as 14-bit signed -> 8191 exceeds; use 2000), ready_in=1 -> data_out 10,0,255 on ch 0,1,2 in consecutive cycles, valid_out first high after edge k+1.
REQ-031 Input 6 -> 1 without RELU_ROUND_EN, 2 with it; input 5 -> 1 in both builds.
REQ-032 ready_in=0 for 5 cycles mid-CH1 -> data_out, ch_out held at CH1 value; resumes CH1->CH2 after ready_in=1.
REQ-033 ready_in=0, 5 consecutive valid_in triplets -> first 4 stored, 5th dropped, overflow=1; drain yields 12 outputs in order.
REQ-034 FIFO full, valid_in coincident with CH2 handshake -> triplet accepted, overflow stays 0.
REQ-035 rst pulse while CH1 with 3 entries queued -> next cycle valid_out=0, overflow=0, no stale outputs afterwards.
